c3po_packer: RTL and testbench



---
 rtl/c3po_packer.sv | 109 ++++++++++
 tb/tb_c3po_packer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/c3po_packer.sv
// c3po_packer: packs 32-byte narrow beats into BEATS_P*32-byte wide words for the c3po ingress bus.
module c3po_packer #(
    parameter int BEATS_P    = 5,
    parameter int CNT_SIZE_P = 8
) (
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic                    i_val,
    input  logic                    i_sop,
    input  logic                    i_eop,
    input  logic [7:0]              i_vbc,
    input  logic [255:0]            i_data,
    output logic                    i_ready,
    output logic                    o_val,
    output logic                    o_sop,
    output logic                    o_eop,
    output logic [7:0]              o_vbc,
    output logic [BEATS_P*256-1:0]  o_data,
    input  logic                    o_ready,
    output logic                    error,
    output logic                    idle,
    output logic [CNT_SIZE_P-1:0]   words_sent,
    output logic [CNT_SIZE_P-1:0]   err_cnt
);
    localparam int IDX_W = $clog2(BEATS_P + 1);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
    state_t                  r_state, w_next;
    logic [IDX_W-1:0]        r_idx, w_k;
    logic [7:0]              r_cnt;
    logic [BEATS_P*256-1:0]  r_acc, w_acc;
    logic [255:0]            w_beat;
    logic                    r_sop, r_eop, r_in_pkt, r_err;
    logic [CNT_SIZE_P-1:0]   r_words, r_errs;
    logic                    w_take, w_drop, w_restart, w_short, w_viol, w_store, w_done, w_pop;
    assign i_ready    = r_state != HOLD;
    assign w_take     = i_val & i_ready;
    assign w_drop     = (~i_sop & ~r_in_pkt) | (i_vbc == 8'd0) | (i_vbc > 8'd32);
    assign w_restart  = i_sop & r_in_pkt;
    assign w_short    = ~i_eop & (i_vbc < 8'd32);
    assign w_viol     = w_take & (w_drop | w_restart | w_short);
    assign w_store    = w_take & ~w_drop;
    assign w_k        = w_restart ? '0 : r_idx;
    assign w_done     = i_eop | (w_k == IDX_W'(BEATS_P - 1));
    assign w_pop      = (r_state == HOLD) & o_ready;
    assign o_val      = r_state == HOLD;
    assign o_sop      = r_sop;
    assign o_eop      = r_eop;
    assign o_vbc      = r_cnt;
    assign o_data     = r_acc;
    assign error      = r_err;
    assign idle       = (r_state == IDLE) & ~r_in_pkt;
    assign words_sent = r_words;
    assign err_cnt    = r_errs;
    // A restarting sop beat throws away the partial word and lands in slot 0.
    always_comb begin
        w_beat = '0;
        for (int b = 0; b < 32; b++)
            w_beat[8*b +: 8] = (8'(b) < i_vbc) ? i_data[8*b +: 8] : 8'h00;
        w_acc = w_restart ? '0 : r_acc;
        w_acc[w_k*256 +: 256] = w_beat;
    end
    always_comb begin
        w_next = r_state;
        if (w_pop)
            w_next = IDLE;
        else if (w_store)
            w_next = w_done ? HOLD : ACCUM;
    end
    always_ff @(posedge clk or posedge reset_L) begin
        if (reset_L)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end
    always_ff @(posedge clk or posedge reset_L) begin
        if (reset_L) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_sop    <= 1'b0;
            r_eop    <= 1'b0;
            r_in_pkt <= 1'b0;
            r_err    <= 1'b0;
            r_words  <= '0;
            r_errs   <= '0;
        end else begin
            r_err <= w_viol;
            if (w_viol & ~&r_errs)
                r_errs <= r_errs + CNT_SIZE_P'(1);
            if (w_pop) begin
                r_acc   <= '0;
                r_cnt   <= '0;
                r_idx   <= '0;
                r_sop   <= 1'b0;
                r_eop   <= 1'b0;
                r_words <= r_words + CNT_SIZE_P'(1);
            end else if (w_store) begin
                // Short non-final beats still occupy a full 32-byte slot.
                r_acc    <= w_acc;
                r_cnt    <= (w_restart ? 8'd0 : r_cnt) + (i_eop ? i_vbc : 8'd32);
                r_idx    <= w_k + IDX_W'(1);
                r_eop    <= i_eop;
                r_in_pkt <= ~i_eop;
                if (w_k == '0)
                    r_sop <= i_sop;
            end
        end
    end
endmodule

// File: tb/tb_c3po_packer.sv
// tb_c3po_packer: directed and random beats checked against a byte-level packet model.
module tb_c3po_packer;
    logic          clk = 1'b0, reset_L = 1'b1;
    logic          i_val = 1'b0, i_sop = 1'b0, i_eop = 1'b0, o_ready = 1'b0;
    logic [7:0]    i_vbc = 8'd0;
    logic [255:0]  i_data = '0;
    logic          i_ready, o_val, o_sop, o_eop, error, idle;
    logic [7:0]    o_vbc, words_sent, err_cnt;
    logic [1279:0] o_data;
    int vectors = 0, miscompares = 0;
    typedef struct {bit sop; bit eop; int vbc; logic [1279:0] data;} word_t;
    word_t         m_q[$];
    bit            m_in_pkt = 0, m_fsop = 0;
    int            m_n = 0, m_vbc = 0, m_err = 0, m_ws = 0;
    logic [1279:0] m_data = '0;

    c3po_packer dut (
        .clk(clk), .reset_L(reset_L), .i_val(i_val), .i_sop(i_sop), .i_eop(i_eop),
        .i_vbc(i_vbc), .i_data(i_data), .i_ready(i_ready), .o_val(o_val), .o_sop(o_sop),
        .o_eop(o_eop), .o_vbc(o_vbc), .o_data(o_data), .o_ready(o_ready), .error(error),
        .idle(idle), .words_sent(words_sent), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(string tag, logic [255:0] obs, logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_data(string tag, logic [1279:0] exp);
        for (int k = 0; k < 5; k++)
            check($sformatf("%s[%0d]", tag, k), o_data[k*256 +: 256], exp[k*256 +: 256]);
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] d;
        for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic model_reset();
        m_in_pkt = 0; m_fsop = 0; m_n = 0; m_vbc = 0; m_err = 0; m_ws = 0; m_data = '0;
        m_q.delete();
    endtask

    // Packet-level view: bytes of each beat land at 32-byte slot offsets of the current word.
    task automatic model_beat(bit sop, bit eop, int vbc, logic [255:0] d, output bit err);
        bit drop;
        drop = (!sop && !m_in_pkt) || vbc == 0 || vbc > 32;
        err  = drop || (sop && m_in_pkt) || (!eop && vbc < 32);
        if (err && m_err < 255) m_err++;
        if (drop) return;
        if (sop) begin m_n = 0; m_data = '0; m_vbc = 0; end
        if (m_n == 0) m_fsop = sop;
        for (int b = 0; b < vbc; b++) m_data[(m_n*32 + b)*8 +: 8] = d[b*8 +: 8];
        m_vbc += eop ? vbc : 32;
        m_n++;
        m_in_pkt = !eop;
        if (eop || m_n == 5) begin
            m_q.push_back('{m_fsop, eop, m_vbc, m_data});
            m_n = 0; m_data = '0; m_vbc = 0;
        end
    endtask

    task automatic beat(bit sop, bit eop, int vbc, logic [255:0] d);
        bit e;
        check("i_ready_before_beat", i_ready, 1);
        i_val = 1; i_sop = sop; i_eop = eop; i_vbc = 8'(vbc); i_data = d;
        model_beat(sop, eop, vbc, d, e);
        @(negedge clk);
        i_val = 0; i_sop = 0; i_eop = 0;
        check("error_pulse", error, e);
        check("err_cnt", err_cnt, m_err);
        check("o_val_latency", o_val, m_q.size() != 0);
    endtask

    task automatic take_word(int hold);
        word_t w;
        for (int t = 0; t < 20 && o_val !== 1'b1; t++) @(negedge clk);
        check("o_val_wait", o_val, 1);
        w = m_q.pop_front();
        check("o_sop", o_sop, w.sop);
        check("o_eop", o_eop, w.eop);
        check("o_vbc", o_vbc, w.vbc);
        check_data("o_data", w.data);
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            check("hold_i_ready", i_ready, 0);
            check("hold_o_val", o_val, 1);
            check("hold_o_vbc", o_vbc, w.vbc);
            check_data("hold_o_data", w.data);
        end
        o_ready = 1;
        @(negedge clk);
        o_ready = 0;
        m_ws++;
        check("post_i_ready", i_ready, 1);
        check("post_o_val", o_val, 0);
        check("words_sent", words_sent, m_ws & 255);
        check("idle", idle, !m_in_pkt);
    endtask

    initial begin
        logic [255:0] d;
        repeat (2) @(negedge clk);
        check("rst_i_ready", i_ready, 1);
        check("rst_o_val", o_val, 0);
        check("rst_idle", idle, 1);
        check("rst_error", error, 0);
        check("rst_words_sent", words_sent, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_o_vbc", o_vbc, 0);
        check_data("rst_o_data", '0);
        reset_L = 0;
        @(negedge clk);
        // single beat, bytes 0x00..0x13 with junk above vbc
        for (int b = 0; b < 32; b++) d[b*8 +: 8] = (b < 20) ? 8'(b) : 8'hAA;
        beat(1, 1, 20, d);
        take_word(0);
        // full word, continuous beats
        for (int k = 0; k < 5; k++) beat(k == 0, k == 4, 32, rnd256());
        take_word(0);
        // long packet: 6x32 + 8 bytes
        for (int k = 0; k < 5; k++) beat(k == 0, 0, 32, rnd256());
        take_word(0);
        beat(0, 0, 32, rnd256());
        beat(0, 1, 8, rnd256());
        take_word(0);
        // backpressure
        beat(1, 0, 32, rnd256());
        beat(0, 1, 17, rnd256());
        take_word(10);
        // protocol errors
        beat(0, 0, 32, rnd256());
        beat(1, 1, 40, rnd256());
        beat(1, 0, 32, rnd256());
        beat(0, 0, 32, rnd256());
        beat(1, 1, 16, rnd256());
        take_word(0);
        check("err_cnt_three", err_cnt, 3);
        // async reset mid-accumulation
        beat(1, 0, 32, rnd256());
        beat(0, 0, 32, rnd256());
        #2 reset_L = 1;
        #1;
        check("arst_o_val", o_val, 0);
        check("arst_i_ready", i_ready, 1);
        check("arst_idle", idle, 1);
        check("arst_words_sent", words_sent, 0);
        check("arst_err_cnt", err_cnt, 0);
        check("arst_o_vbc", o_vbc, 0);
        check_data("arst_o_data", '0);
        model_reset();
        @(negedge clk);
        reset_L = 0;
        @(negedge clk);
        beat(1, 1, 10, rnd256());
        take_word(0);
        // random traffic including violations
        for (int n = 0; n < 80; n++) begin
            int  r, vbc;
            bit  sop, eop;
            r   = int'($urandom % 16);
            sop = m_in_pkt ? (r == 1) : (r != 0);
            eop = ($urandom % 3) == 0;
            vbc = eop ? int'($urandom_range(1, 32)) : (($urandom % 6) == 0 ? int'($urandom_range(1, 31)) : 32);
            if (r == 2) vbc = ($urandom % 2) ? 0 : int'($urandom_range(33, 60));
            beat(sop, eop, vbc, rnd256());
            if (m_q.size() != 0) take_word(int'($urandom % 4));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
